// File: rtl/tone_sequencer_if.sv
// Playback-control, pattern-write and step-output signals of tone_sequencer.
// The master side is the controlling logic (top-level FSM / pattern loader).
// The slave side is the sequencer itself.
interface tone_sequencer_if #(
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 24,
    parameter int DUR_W    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                tick;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [PERIOD_W-1:0] wr_period;
    logic [DUR_W-1:0]    wr_dur;
    logic [AW:0]         seq_len;
    logic                start;
    logic                stop;
    logic [PERIOD_W-1:0] period_out;
    logic                gate;
    logic [AW-1:0]       step_idx;
    logic                step_pulse;
    logic                busy;
    logic                done;

    modport master (
        output tick, wr_en, wr_addr, wr_period, wr_dur, seq_len, start, stop,
        input  period_out, gate, step_idx, step_pulse, busy, done
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_period, wr_dur, seq_len, start, stop,
        output period_out, gate, step_idx, step_pulse, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a pattern memory of {period, duration} notes,
// advancing on tick pulses, and presents the current step's period and gate
// to the tone generator. Duration 0 is a one-tick rest (gate low).
// Build option: define SEQ_LOOP_EN to wrap from the last step back to step 0
// forever instead of stopping in DONE.
module tone_sequencer #(
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 24,
    parameter int DUR_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    tone_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [PERIOD_W-1:0] r_mem_period [DEPTH];
    logic [DUR_W-1:0]    r_mem_dur    [DEPTH];
    logic [AW:0]         r_len;
    logic [AW-1:0]       r_step;
    logic [DUR_W-1:0]    r_tick_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_gate;
    logic                r_pulse;
    logic                r_busy;
    logic                r_done;

    logic [DUR_W-1:0]    w_cur_dur;
    logic [DUR_W-1:0]    w_last_cnt;
    logic                w_step_end;
    logic                w_last_step;
    logic [AW-1:0]       w_next_step;
    logic [AW:0]         w_len_clamped;
    logic                w_start_ok;

    assign w_cur_dur     = r_mem_dur[r_step];
    // A rest (dur 0) lasts one tick, same as dur 1.
    assign w_last_cnt    = (w_cur_dur == '0) ? '0 : w_cur_dur - 1'b1;
    assign w_step_end    = bus.tick && (r_tick_cnt == w_last_cnt);
    assign w_last_step   = (({1'b0, r_step} + (AW+1)'(1)) == r_len);
    assign w_next_step   = r_step + AW'(1);
    assign w_len_clamped = (bus.seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.seq_len;
    assign w_start_ok    = bus.start && !bus.stop && (bus.seq_len != '0);

    assign bus.period_out = r_period;
    assign bus.gate       = r_gate;
    assign bus.step_idx   = r_step;
    assign bus.step_pulse = r_pulse;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // Pattern memory: not reset, writable only while not playing.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (r_state != PLAY)) begin
            r_mem_period[bus.wr_addr] <= bus.wr_period;
            r_mem_dur[bus.wr_addr]    <= bus.wr_dur;
        end
    end

    // Playback FSM with registered step outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_step     <= '0;
            r_tick_cnt <= '0;
            r_period   <= '0;
            r_gate     <= 1'b0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state    <= PLAY;
                        r_len      <= w_len_clamped;
                        r_step     <= '0;
                        r_tick_cnt <= '0;
                        r_period   <= r_mem_period[0];
                        r_gate     <= (r_mem_dur[0] != '0);
                        r_pulse    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        r_state    <= IDLE;
                        r_step     <= '0;
                        r_tick_cnt <= '0;
                        r_period   <= '0;
                        r_gate     <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_step_end) begin
                        r_tick_cnt <= '0;
                        if (!w_last_step) begin
                            r_step   <= w_next_step;
                            r_period <= r_mem_period[w_next_step];
                            r_gate   <= (r_mem_dur[w_next_step] != '0);
                            r_pulse  <= 1'b1;
                        end else begin
`ifdef SEQ_LOOP_EN
                            r_step   <= '0;
                            r_period <= r_mem_period[0];
                            r_gate   <= (r_mem_dur[0] != '0);
                            r_pulse  <= 1'b1;
`else
                            r_state  <= DONE;
                            r_period <= '0;
                            r_gate   <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
`endif
                        end
                    end else if (bus.tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Consumes the one-cycle tick pulses produced by the project's tick/period counter and steps through a small pattern memory of notes.
- Each note has a tone period and a duration in ticks.
- Per step, outputs a registered period value and a gate for the downstream tone generator / PWM stage.
- Runs start/stop playback control for the top-level FSM.

Parameters:
- DEPTH, 16, number of pattern entries (power of two, ≥2); AW = log2(DEPTH)
- PERIOD_W, 24, width of the stored tone period
- DUR_W, 8, width of the stored step duration in ticks

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse from the tick counter; may be asserted on consecutive cycles
- wr_en  in  1  pattern write strobe
- wr_addr  in  AW  pattern write address
- wr_period  in  PERIOD_W  period written to wr_addr
- wr_dur  in  DUR_W  duration (ticks) written to wr_addr; 0 = one-tick rest
- seq_len  in  AW+1  number of active steps, sampled on start
- start  in  1  begin playback at step 0
- stop  in  1  abort playback
- period_out  out  PERIOD_W  period of current step (registered)
- gate  out  1  high while a non-rest step plays (registered)
- step_idx  out  AW  current step index (registered)
- step_pulse  out  1  one-cycle pulse on the cycle a new step begins (registered)
- busy  out  1  playback active (registered)
- done  out  1  sequence completed, held until next start or reset (registered)

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0.
  - Internal step and tick counters go to 0.
  - Pattern memory is NOT reset; it retains its contents across reset.
- Memory:
  - DEPTH entries of {period, dur}, combinational read at step_idx.
  - A write takes effect at the clock edge when wr_en=1 and state is IDLE or DONE.
  - Writes while busy are ignored.
- States: IDLE, PLAY, DONE.
- IDLE/DONE + start, with seq_len≠0:
  - len_q <= min(seq_len, DEPTH); step <= 0; tick_cnt <= 0; state goes to PLAY.
  - On the next cycle: busy=1, done=0, step_idx=0, period_out=mem[0].period, gate=(mem[0].dur≠0), step_pulse=1.
- start with seq_len=0 is ignored. start while in PLAY is ignored.
- PLAY step end:
  - A step ends on a cycle with tick=1 and tick_cnt == max(dur,1)-1.
  - Otherwise, tick increments tick_cnt.
  - Cycles without tick hold all state.
- On step end, if step < len_q-1:
  - step+1, tick_cnt <= 0.
  - Next cycle: new step_idx/period_out/gate, step_pulse=1.
- On step end, if step == len_q-1: end-of-sequence handling (see Optional Feature).
- Latency: tick on cycle M ending a step → new outputs and step_pulse on cycle M+1. Back-to-back ticks with dur=1 advance one step per cycle.
- stop in PLAY:
  - Next cycle: IDLE; busy=0, gate=0, period_out=0, step_pulse=0, step_idx=0.
  - stop in IDLE/DONE has no effect.
- Precedence (same cycle):
  - stop beats a step-ending tick: no step_pulse.
  - stop beats start.
  - A write and start in the same cycle: the write lands, and start reads the memory contents from before the write.
- DONE: busy=0, gate=0, period_out=0, done=1, step_idx holds the last step.
- step_pulse is high for exactly one cycle per step entered.
- tick_cnt width is DUR_W; it cannot overflow because it is bounded by dur-1.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - End of the last step wraps to step 0 (tick_cnt <= 0, step_pulse=1, step_idx=0 next cycle).
  - Playback continues until stop or reset; done never asserts.
- Undefined:
  - End of the last step goes to DONE on the next cycle, with DONE-state outputs as above.

Test Plan:
- Write {1000,2}, {2000,1}, {3000,3} at addr 0-2; seq_len=3; start; tick every 4 cycles → busy and step_pulse 1 cycle after start.
  - step_idx=0/period 1000 for 2 ticks, then 1/2000 for 1 tick, then 2/3000 for 3 ticks.
  - Cycle after the 6th tick: done=1, gate=0, period_out=0, busy=0 (no SEQ_LOOP_EN).
- Entry 1 dur=0 (rest), tick every cycle → step 1 lasts exactly 1 tick with gate=0 and period_out=2000; gate returns to 1 on step 2.
- All durs=1, tick held high continuously → step_idx 0,1,2 on consecutive cycles, step_pulse high 3 consecutive cycles.
- stop asserted on the same cycle as a step-ending tick at step 1 → next cycle IDLE, busy=0, step_pulse=0, gate=0.
- Boundary cases:
  - seq_len=0 with start → no response.
  - seq_len=20 with DEPTH=16 → plays 16 steps.
  - wr_en during PLAY → memory unchanged (verified on a replay).
- reset mid-play at step 1 → all outputs 0 next cycle; restart → plays entry 0 with the previously written values.
- With SEQ_LOOP_EN: after step 2 ends, step_idx=0 and step_pulse=1 next cycle; done stays 0 across 3 full loops.
